// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit for port B of the dual-port main memory.
// Converts one byte/half/word request at any byte address into word-aligned
// memory beats with byte enables, lane-shifts store data and extracts plus
// sign/zero-extends load data from the 1-cycle-latency RAM.
// Optional feature macro: MEM_ACCESS_SPLIT_EN
//   defined   -> word-crossing accesses are split into two beats (ACC0, ACC1)
//   undefined -> word-crossing accesses are rejected with rsp_err
module mem_access_unit #(
  parameter int MEM_SIZE = 8192,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_data_en,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

`ifdef MEM_ACCESS_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_RSP, S_ERR} state_t;

  // Byte mask of an access before it is moved to its lane.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      2'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Byte enables across the two words an access may touch.
  function automatic logic [7:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    return {4'b0000, size_mask(size)} << off;
  endfunction

  // Store data moved into lane position across two words.
  function automatic logic [63:0] lane_data(input logic [31:0] d, input logic [1:0] off);
    return {32'h0000_0000, d} << {off, 3'b000};
  endfunction

  state_t              state_q, state_d;
  logic                we_q, uns_q, split_q;
  logic [1:0]          size_q, off_q;
  logic [31:0]         wdata_q, lo_q;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                accept_s, cross_s;
  logic [63:0]         rd64_s;
  logic [31:0]         rd_s, ext_s;

  assign accept_s = req_valid && (state_q == S_IDLE);
  assign cross_s  = ((req_size == 2'd2) && (req_addr[1:0] != 2'd0)) ||
                    ((req_size == 2'd1) && (req_addr[1:0] == 2'd3));

  // Next-state logic: accept in IDLE, one or two beats, then a response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if ((req_size == 2'd3) || (cross_s && !SPLIT_EN)) state_d = S_ERR;
          else                                              state_d = S_ACC0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC0:  state_d = split_q ? S_ACC1 : S_RSP;
      S_ACC1:  state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port next values: first beat loaded on accept, second beat after ACC0.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 4'b0000;
    mem_we_d    = 1'b0;
    if (accept_s && (state_d == S_ACC0)) begin
      mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
      mem_en_d    = lane_en(req_size, req_addr[1:0])[3:0];
      mem_wdata_d = lane_data(req_wdata, req_addr[1:0])[31:0];
      mem_we_d    = req_we;
    end else if ((state_q == S_ACC0) && split_q) begin
      mem_addr_d  = mem_addr_q + WORD_STEP;  // wraps modulo MEM_SIZE
      mem_en_d    = lane_en(size_q, off_q)[7:4];
      mem_wdata_d = lane_data(wdata_q, off_q)[63:32];
      mem_we_d    = we_q;
    end else begin
      mem_en_d    = 4'b0000;
      mem_we_d    = 1'b0;
    end
  end

  // Load data: combine the captured low word with live RAM data, align, extend.
  always_comb begin
    if (split_q) rd64_s = {mem_rdata, lo_q};
    else         rd64_s = {32'h0000_0000, mem_rdata};
    rd_s = rd64_s[{off_q, 3'b000} +: 32];
    case (size_q)
      2'd0:    ext_s = uns_q ? {24'h00_0000, rd_s[7:0]}  : {{24{rd_s[7]}}, rd_s[7:0]};
      2'd1:    ext_s = uns_q ? {16'h0000, rd_s[15:0]}    : {{16{rd_s[15]}}, rd_s[15:0]};
      default: ext_s = rd_s;
    endcase
  end

  // State and memory-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      mem_en_q    <= 4'b0000;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Request capture on accept; low read word captured during the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      wdata_q <= 32'h0000_0000;
      lo_q    <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        split_q <= cross_s && SPLIT_EN;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
      end
      if (state_q == S_ACC1) lo_q <= mem_rdata;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RSP) || (state_q == S_ERR);
  assign rsp_err     = (state_q == S_ERR);
  assign rsp_rdata   = ((state_q == S_RSP) && !we_q) ? ext_s : 32'h0000_0000;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_data_en = mem_en_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 1-cycle RAM model.
// Expectations follow MEM_ACCESS_SPLIT_EN when it is defined for the build.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_data_en;
  logic        mem_we;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:2047];
  logic [12:0] b_addr [1:6];
  logic [31:0] b_wd   [1:6];
  logic [3:0]  b_en   [1:6];
  logic        b_we   [1:6];
  int          r_lat, r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_en(mem_data_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr[12:2]];
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_data_en[i]) ram[mem_addr[12:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Issue one request at a negedge and record six cycles of port activity.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [12:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 0; r_cnt = 0; r_rdata = 32'h0; r_err = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      b_addr[k] = mem_addr; b_wd[k] = mem_wdata; b_en[k] = mem_data_en; b_we[k] = mem_we;
      if (rsp_valid) begin
        r_cnt++;
        if (r_lat == 0) begin r_lat = k; r_rdata = rsp_rdata; r_err = rsp_err; end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 13'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin errors++;
      $display("FAIL reset_hs got %b exp 100", {req_ready, rsp_valid, rsp_err}); end
    checks++; if ({mem_we, mem_data_en, mem_addr, mem_wdata, rsp_rdata} !== 82'h0) begin errors++;
      $display("FAIL reset_mem we=%b en=%b addr=%h wd=%h rd=%h exp all 0", mem_we, mem_data_en, mem_addr, mem_wdata, rsp_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_byte;
    run_req(1'b1, 2'd0, 1'b0, 13'h006, 32'h0000_00AB);
    checks++; if ({b_addr[1], b_en[1], b_wd[1], b_we[1]} !== {13'h004, 4'b0100, 32'h00AB_0000, 1'b1}) begin errors++;
      $display("FAIL sb_beat got addr=%h en=%b wd=%h we=%b exp 004 0100 00ab0000 1", b_addr[1], b_en[1], b_wd[1], b_we[1]); end
    checks++; if ({r_lat, r_cnt, r_err, r_rdata} !== {32'd2, 32'd1, 1'b0, 32'h0}) begin errors++;
      $display("FAIL sb_rsp got lat=%0d cnt=%0d err=%b rd=%h exp 2 1 0 0", r_lat, r_cnt, r_err, r_rdata); end
    checks++; if ({b_we[2], b_en[2]} !== 5'b0) begin errors++;
      $display("FAIL sb_idle_beat got we=%b en=%b exp 0 0000", b_we[2], b_en[2]); end
    run_req(1'b0, 2'd0, 1'b1, 13'h006, 32'h0);
    checks++; if ({r_lat, r_err, r_rdata} !== {32'd2, 1'b0, 32'h0000_00AB}) begin errors++;
      $display("FAIL lbu got lat=%0d err=%b rd=%h exp 2 0 000000ab", r_lat, r_err, r_rdata); end
    checks++; if ({b_we[1], b_en[1]} !== {1'b0, 4'b0100}) begin errors++;
      $display("FAIL lbu_beat got we=%b en=%b exp 0 0100", b_we[1], b_en[1]); end
  endtask

  task automatic test_extend;
    run_req(1'b1, 2'd2, 1'b0, 13'h000, 32'h8001_8000);
    checks++; if ({b_en[1], b_wd[1], b_we[1]} !== {4'b1111, 32'h8001_8000, 1'b1}) begin errors++;
      $display("FAIL sw0_beat got en=%b wd=%h we=%b exp 1111 80018000 1", b_en[1], b_wd[1], b_we[1]); end
    run_req(1'b0, 2'd1, 1'b0, 13'h002, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_8001) begin errors++;
      $display("FAIL lh got %h exp ffff8001", r_rdata); end
    run_req(1'b0, 2'd1, 1'b1, 13'h002, 32'h0);
    checks++; if (r_rdata !== 32'h0000_8001) begin errors++;
      $display("FAIL lhu got %h exp 00008001", r_rdata); end
    run_req(1'b0, 2'd0, 1'b0, 13'h001, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_FF80) begin errors++;
      $display("FAIL lb got %h exp ffffff80", r_rdata); end
  endtask

  task automatic test_cross;
    logic saw_we;
    run_req(1'b1, 2'd2, 1'b0, 13'h005, 32'h1122_3344);
`ifdef MEM_ACCESS_SPLIT_EN
    checks++; if ({b_addr[1], b_en[1], b_wd[1], b_we[1]} !== {13'h004, 4'b1110, 32'h2233_4400, 1'b1}) begin errors++;
      $display("FAIL sw_x_beat0 got %h %b %h %b exp 004 1110 22334400 1", b_addr[1], b_en[1], b_wd[1], b_we[1]); end
    checks++; if ({b_addr[2], b_en[2], b_wd[2], b_we[2]} !== {13'h008, 4'b0001, 32'h0000_0011, 1'b1}) begin errors++;
      $display("FAIL sw_x_beat1 got %h %b %h %b exp 008 0001 00000011 1", b_addr[2], b_en[2], b_wd[2], b_we[2]); end
    checks++; if ({r_lat, r_err} !== {32'd3, 1'b0}) begin errors++;
      $display("FAIL sw_x_rsp got lat=%0d err=%b exp 3 0", r_lat, r_err); end
    run_req(1'b0, 2'd2, 1'b0, 13'h005, 32'h0);
    checks++; if ({r_lat, r_err, r_rdata} !== {32'd3, 1'b0, 32'h1122_3344}) begin errors++;
      $display("FAIL lw_x got lat=%0d err=%b rd=%h exp 3 0 11223344", r_lat, r_err, r_rdata); end
    run_req(1'b0, 2'd1, 1'b1, 13'h003, 32'h0);
    checks++; if ({r_lat, r_err, r_rdata} !== {32'd3, 1'b0, 32'h0000_0080}) begin errors++;
      $display("FAIL lhu_x got lat=%0d err=%b rd=%h exp 3 0 00000080", r_lat, r_err, r_rdata); end
`else
    saw_we = 1'b0;
    for (int k = 1; k <= 6; k++) saw_we = saw_we | b_we[k];
    checks++; if ({r_lat, r_err, r_rdata, saw_we} !== {32'd1, 1'b1, 32'h0, 1'b0}) begin errors++;
      $display("FAIL sw_x_err got lat=%0d err=%b rd=%h we_seen=%b exp 1 1 0 0", r_lat, r_err, r_rdata, saw_we); end
    run_req(1'b0, 2'd1, 1'b1, 13'h003, 32'h0);
    checks++; if ({r_lat, r_err, r_cnt} !== {32'd1, 1'b1, 32'd1}) begin errors++;
      $display("FAIL lhu_x_err got lat=%0d err=%b cnt=%0d exp 1 1 1", r_lat, r_err, r_cnt); end
`endif
  endtask

  task automatic test_wrap;
    run_req(1'b1, 2'd2, 1'b0, 13'h1FFC, 32'hDEAD_BEEF);
    run_req(1'b1, 2'd2, 1'b0, 13'h0000, 32'hCAFE_F00D);
    run_req(1'b0, 2'd2, 1'b0, 13'h1FFE, 32'h0);
`ifdef MEM_ACCESS_SPLIT_EN
    checks++; if ({b_addr[1], b_en[1], b_addr[2], b_en[2]} !== {13'h1FFC, 4'b1100, 13'h0000, 4'b0011}) begin errors++;
      $display("FAIL wrap_beats got %h %b %h %b exp 1ffc 1100 0000 0011", b_addr[1], b_en[1], b_addr[2], b_en[2]); end
    checks++; if ({r_lat, r_err, r_rdata} !== {32'd3, 1'b0, 32'hF00D_DEAD}) begin errors++;
      $display("FAIL wrap_data got lat=%0d err=%b rd=%h exp 3 0 f00ddead", r_lat, r_err, r_rdata); end
`else
    checks++; if ({r_lat, r_err} !== {32'd1, 1'b1}) begin errors++;
      $display("FAIL wrap_err got lat=%0d err=%b exp 1 1", r_lat, r_err); end
    run_req(1'b0, 2'd2, 1'b0, 13'h1FFC, 32'h0);
    checks++; if (r_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL top_word got %h exp deadbeef", r_rdata); end
`endif
  endtask

  task automatic test_illegal_and_abort;
    logic saw;
    run_req(1'b0, 2'd3, 1'b0, 13'h004, 32'h0);
    checks++; if ({r_lat, r_cnt, r_err, r_rdata, b_we[1], b_en[1]} !== {32'd1, 32'd1, 1'b1, 32'h0, 1'b0, 4'b0000}) begin errors++;
      $display("FAIL size3 got lat=%0d cnt=%0d err=%b rd=%h we=%b en=%b exp 1 1 1 0 0 0000", r_lat, r_cnt, r_err, r_rdata, b_we[1], b_en[1]); end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 13'h010; req_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({mem_we, mem_addr} !== {1'b1, 13'h010}) begin errors++;
      $display("FAIL abort_beat got we=%b addr=%h exp 1 010", mem_we, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_we, mem_data_en, mem_addr, req_ready, rsp_valid} !== {1'b0, 4'b0, 13'h0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL abort_reset got we=%b en=%b addr=%h rdy=%b vld=%b exp 0 0000 0000 1 0", mem_we, mem_data_en, mem_addr, req_ready, rsp_valid); end
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); saw = saw | rsp_valid; end
    checks++; if (saw !== 1'b0) begin errors++;
      $display("FAIL abort_no_rsp got rsp_valid seen=%b exp 0", saw); end
    run_req(1'b0, 2'd2, 1'b0, 13'h010, 32'h0);
    checks++; if (r_lat !== 2) begin errors++;
      $display("FAIL post_abort_lat got %0d exp 2", r_lat); end
  endtask

  initial begin
    test_reset;
    @(negedge clk);
    test_byte;
    test_extend;
    test_cross;
    test_wrap;
    test_illegal_and_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
